// File: rtl/load_store_unit.sv
// Memory-access stage: performs lw/sh/sb/... against a word-wide data memory over a
// request/acknowledge handshake. It builds byte enables and lane-replicated write data for
// stores, aligns and sign-extends sub-word loads, and stalls the pipeline while busy.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             access request this cycle
//   write             1 = store, 0 = load
//   size              00 word, 01 half, 10 byte, 11 word
//   addr              effective byte address
//   write_data        right-justified store data
//   busy              stall request to the pipeline (combinational)
//   done              one-cycle completion pulse
//   read_data         aligned, sign-extended load result (registered)
//   misalign_err      valid with done; access was misaligned
//   mem_req/mem_we    memory request / write enable
//   mem_addr          word address
//   mem_byte_en       byte-lane enables
//   mem_wdata         lane-positioned write data
//   mem_rdata/mem_ack memory read data / completion
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data,
  output logic        misalign_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        misalign_q, misalign_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  // Decode of the incoming request.
  logic        is_word, is_half, is_byte;
  logic        misaligned;
  logic [3:0]  req_byte_en;
  logic [31:0] req_wdata;

  always_comb begin
    is_word    = (size == 2'b00) || (size == 2'b11);
    is_half    = (size == 2'b01);
    is_byte    = (size == 2'b10);
    misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    req_byte_en = 4'b1111;
    req_wdata   = write_data;
    if (is_half) begin
      req_byte_en = addr[1] ? 4'b1100 : 4'b0011;
      req_wdata   = {2{write_data[15:0]}};
    end else if (is_byte) begin
      req_byte_en = 4'b0001 << addr[1:0];
      req_wdata   = {4{write_data[7:0]}};
    end
  end

  // Load alignment: shift the addressed lane down to bit 0, then sign-extend.
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_val = mem_rdata;
    case (size_q)
      2'b10:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_wdata_d   = mem_wdata_q;
    read_data_d   = read_data_q;
    misalign_d    = misalign_q;
    size_d        = size_q;
    off_d         = off_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (misaligned) begin
            // Complete immediately without touching memory.
            state_d     = StDone;
            read_data_d = 32'h0;
            misalign_d  = 1'b1;
          end else begin
            state_d       = StReq;
            mem_req_d     = 1'b1;
            mem_we_d      = write;
            mem_addr_d    = {addr[31:2], 2'b00};
            mem_byte_en_d = req_byte_en;
            mem_wdata_d   = req_wdata;
            size_d        = size;
            off_d         = addr[1:0];
          end
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d       = StDone;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_addr_d    = 32'h0;
          mem_byte_en_d = 4'h0;
          mem_wdata_d   = 32'h0;
          read_data_d   = mem_we_q ? 32'h0 : load_val;
          misalign_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_byte_en_q <= 4'h0;
      mem_wdata_q   <= 32'h0;
      read_data_q   <= 32'h0;
      misalign_q    <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wdata_q   <= mem_wdata_d;
      read_data_q   <= read_data_d;
      misalign_q    <= misalign_d;
      size_q        <= size_d;
      off_q         <= off_d;
    end
  end

  assign busy         = (start && (state_q != StReq)) || (state_q == StReq);
  assign done         = (state_q == StDone);
  assign read_data    = read_data_q;
  assign misalign_err = misalign_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_byte_en  = mem_byte_en_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] read_data;
  logic        misalign_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int passes = 0;

  load_store_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .write       (write),
    .size        (size),
    .addr        (addr),
    .write_data  (write_data),
    .busy        (busy),
    .done        (done),
    .read_data   (read_data),
    .misalign_err(misalign_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_byte_en (mem_byte_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] wd);
    start      = 1'b1;
    write      = w;
    size       = s;
    addr       = a;
    write_data = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({done, mem_req, mem_we, misalign_err, busy} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_byte_en !== 4'h0 || mem_wdata !== 32'h0 || read_data !== 32'h0)
      $display("FAIL reset_outputs: got done=%b req=%b we=%b err=%b busy=%b addr=%h be=%b wd=%h rd=%h, want all 0",
               done, mem_req, mem_we, misalign_err, busy, mem_addr, mem_byte_en, mem_wdata,
               read_data);
    else passes++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sw();
    request(1'b1, 2'b00, 32'h0000_1000, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (busy !== 1'b1) $display("FAIL sw_busy_start: got %b want 1", busy); else passes++;
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h1000 ||
        mem_byte_en !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL sw_req: got req=%b we=%b addr=%h be=%b wd=%h busy=%b done=%b, want 1 1 1000 1111 deadbeef 1 0",
               mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata, busy, done);
    else passes++;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 ||
        read_data !== 32'h0 || misalign_err !== 1'b0)
      $display("FAIL sw_done: got done=%b req=%b we=%b busy=%b rd=%h err=%b, want 1 0 0 0 0 0",
               done, mem_req, mem_we, busy, read_data, misalign_err);
    else passes++;
    step();
    checks++;
    if (done !== 1'b0) $display("FAIL sw_done_pulse: got %b want 0", done); else passes++;
  endtask

  task automatic test_sb();
    request(1'b1, 2'b10, 32'h0000_1003, 32'h0000_00AB);
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    checks++;
    if (mem_addr !== 32'h1000 || mem_byte_en !== 4'b1000 || mem_wdata[31:24] !== 8'hAB ||
        mem_we !== 1'b1)
      $display("FAIL sb_req: got addr=%h be=%b wd=%h we=%b, want 1000 1000 AB.. 1",
               mem_addr, mem_byte_en, mem_wdata, mem_we);
    else passes++;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1) $display("FAIL sb_done: got %b want 1", done); else passes++;
    step();
  endtask

  task automatic test_loads();
    request(1'b0, 2'b10, 32'h0000_2002, 32'h0);
    step();
    start = 1'b0;
    checks++;
    if (mem_byte_en !== 4'b0100 || mem_we !== 1'b0 || mem_addr !== 32'h2000)
      $display("FAIL lb_req: got be=%b we=%b addr=%h, want 0100 0 2000",
               mem_byte_en, mem_we, mem_addr);
    else passes++;
    mem_ack = 1'b1;
    mem_rdata = 32'h0080_0000;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || read_data !== 32'hFFFF_FF80)
      $display("FAIL lb_data: got done=%b rd=%h, want 1 ffffff80", done, read_data);
    else passes++;
    step();
    request(1'b0, 2'b01, 32'h0000_2002, 32'h0);
    step();
    start = 1'b0;
    checks++;
    if (mem_byte_en !== 4'b1100)
      $display("FAIL lh_be: got %b want 1100", mem_byte_en);
    else passes++;
    mem_ack = 1'b1;
    mem_rdata = 32'h7FFF_0000;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || read_data !== 32'h0000_7FFF)
      $display("FAIL lh_data: got done=%b rd=%h, want 1 00007fff", done, read_data);
    else passes++;
    step();
    checks++;
    if (read_data !== 32'h0000_7FFF)
      $display("FAIL lh_hold: got %h want 00007fff", read_data);
    else passes++;
  endtask

  task automatic test_delayed_ack();
    int dones;
    dones = 0;
    request(1'b0, 2'b00, 32'h0000_4000, 32'h0);
    step();
    start = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || mem_byte_en !== 4'b1111 || busy !== 1'b1)
        $display("FAIL lw_delay_hold%0d: got req=%b addr=%h be=%b busy=%b, want 1 4000 1111 1",
                 i, mem_req, mem_addr, mem_byte_en, busy);
      else passes++;
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    if (done) dones++;
    checks++;
    if (done !== 1'b1 || read_data !== 32'hCAFE_F00D)
      $display("FAIL lw_delay_done: got done=%b rd=%h, want 1 cafef00d", done, read_data);
    else passes++;
    step();
    if (done) dones++;
    checks++;
    if (dones != 1) $display("FAIL lw_delay_pulses: got %0d want 1", dones); else passes++;
  endtask

  task automatic test_back_to_back();
    request(1'b0, 2'b00, 32'h0000_3000, 32'h0);
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || read_data !== 32'h1234_5678)
      $display("FAIL b2b_lw: got done=%b rd=%h, want 1 12345678", done, read_data);
    else passes++;
    // New store presented in the DONE cycle.
    request(1'b1, 2'b01, 32'h0000_3002, 32'h1234_CDEF);
    #1;
    checks++;
    if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passes++;
    step();
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_byte_en !== 4'b1100 || mem_wdata !== 32'hCDEF_CDEF)
      $display("FAIL b2b_sh_req: got req=%b be=%b wd=%h, want 1 1100 cdefcdef",
               mem_req, mem_byte_en, mem_wdata);
    else passes++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || read_data !== 32'h0)
      $display("FAIL b2b_sh_done: got done=%b rd=%h, want 1 0", done, read_data);
    else passes++;
    step();
  endtask

  task automatic test_misalign();
    mem_rdata = 32'h5555_AAAA;
    request(1'b0, 2'b01, 32'h0000_5000, 32'h0);
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    request(1'b0, 2'b00, 32'h0000_1002, 32'h0);
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || misalign_err !== 1'b1 || read_data !== 32'h0 || mem_req !== 1'b0)
      $display("FAIL misalign_done: got done=%b err=%b rd=%h req=%b, want 1 1 0 0",
               done, misalign_err, read_data, mem_req);
    else passes++;
    step();
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL misalign_idle: got done=%b req=%b, want 0 0", done, mem_req);
    else passes++;
    request(1'b0, 2'b10, 32'h0000_1001, 32'h0);
    step();
    start = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_7F00;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || misalign_err !== 1'b0 || read_data !== 32'h0000_007F)
      $display("FAIL misalign_next: got done=%b err=%b rd=%h, want 1 0 0000007f",
               done, misalign_err, read_data);
    else passes++;
    step();
  endtask

  task automatic test_reset_mid_access();
    request(1'b1, 2'b00, 32'h0000_6000, 32'h1111_2222);
    step();
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_byte_en !== 4'h0 ||
        mem_wdata !== 32'h0 || done !== 1'b0 || read_data !== 32'h0 || busy !== 1'b0)
      $display("FAIL reset_mid: got req=%b we=%b addr=%h be=%b wd=%h done=%b rd=%h busy=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata, done, read_data, busy);
    else passes++;
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL reset_late_ack1: got done=%b req=%b, want 0 0", done, mem_req);
    else passes++;
    step();
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL reset_late_ack2: got done=%b req=%b, want 0 0", done, mem_req);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_loads();
    test_delayed_ack();
    test_back_to_back();
    test_misalign();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that sits directly downstream of the execute-stage ALU: it takes the ALU's effective address (base + offset) together with the store data and access type, and performs lw/sw/lh/sh/lb/sb against a word-wide data memory over a request/acknowledge handshake of variable latency. It generates byte enables and lane-shifted write data for sub-word stores, and aligns and sign-extends sub-word loads. It also produces a stall signal for the pipeline while an access is outstanding.

## Interface
Parameters: none.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- Start  in  1  valid access request this cycle
- Write  in  1  1 = store, 0 = load
- Size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- Addr  in  32  effective byte address (ALU result)
- WriteData  in  32  store data, right-justified
- Busy  out  1  stall request to pipeline
- Done  out  1  one-cycle completion pulse
- ReadData  out  32  aligned, sign-extended load result
- MisalignErr  out  1  valid with Done; access was misaligned
- MemReq  out  1  memory request
- MemWe  out  1  memory write enable, qualified by MemReq
- MemAddr  out  32  word address: {Addr[31:2], 2'b00}
- MemByteEn  out  4  byte-lane enables
- MemWData  out  32  lane-positioned write data
- MemRData  in  32  memory read data, valid when MemAck=1
- MemAck  in  1  memory completion, sampled on the rising edge

## Operation
- Byte ordering is little-endian: the byte at offset k = Addr[1:0] occupies bits [8k+7:8k].
- FSM states: IDLE, REQ, DONE.
  - IDLE: if Start is sampled high and the access is aligned, register the access and go to REQ. If Start is high and the access is misaligned, go to DONE with MisalignErr set. Otherwise stay in IDLE.
  - REQ: hold MemReq=1. When MemAck is sampled high, capture the read data (loads) and go to DONE.
  - DONE: Done=1 for this cycle. If Start is high, process it exactly as IDLE would (back-to-back accesses). Otherwise go to IDLE.
- Misaligned accesses: word with Addr[1:0]≠0, or half with Addr[0]≠0. No memory request is issued. ReadData=0 and MisalignErr=1 during the DONE cycle.
- Byte enables:
  - word: 1111
  - half: 0011 when Addr[1]=0, 1100 when Addr[1]=1
  - byte: one-hot 1<<Addr[1:0]
- MemWData: WriteData replicated to every lane (byte ×4, half ×2, word as-is), so the enabled lanes carry the correct data.
- Loads:
  - the selected lane is shifted down to bit 0 and sign-extended from bit 7 (lb) or bit 15 (lh); lw passes through.
  - MemByteEn carries the same pattern as for stores.
  - after a store, ReadData is 0.
- ReadData and MisalignErr are registered. They update only on entry to DONE and hold until the next DONE.
- Start is ignored while in REQ; upstream holds the request while Busy=1.

## Timing
- Reset values (asserted asynchronously; take effect immediately, including mid-access):
  - state IDLE
  - Done, MemReq, MemWe, MisalignErr: 0
  - MemAddr, MemByteEn, MemWData, ReadData: 0
  - An outstanding access is abandoned. An ack arriving after reset is ignored.
- MemReq, MemWe, MemAddr, MemByteEn and MemWData are registered and held stable for the whole REQ state.
- Busy is combinational: (Start & state≠REQ) | (state==REQ). It is 0 in the DONE cycle unless a new Start is present.
- Latency from Start sampled (edge 0):
  - MemReq asserts after edge 0.
  - With MemAck high at edge 1, Done is high after edge 1. This is the minimum two-cycle occupancy.
  - Each cycle of ack delay adds one cycle.
- Misaligned access: Done and MisalignErr are high in the cycle after Start is sampled, with no MemReq.
- If MemAck is high while state≠REQ, it is ignored.

## Test plan
- sw, Addr=0x0000_1000, WriteData=0xDEAD_BEEF, MemAck high in the first REQ cycle -> MemReq/MemWe for exactly 1 cycle, MemByteEn=1111, MemWData=0xDEADBEEF; Done on the next cycle; Busy high for 2 cycles.
- sb, Addr=0x0000_1003, WriteData=0x0000_00AB -> MemAddr=0x1000, MemByteEn=1000, MemWData[31:24]=0xAB.
- lb, Addr=0x0000_2002, MemRData=0x0080_0000 -> ReadData=0xFFFF_FF80. Then lh, Addr=0x2002, MemRData=0x7FFF_0000 -> ReadData=0x0000_7FFF.
- lw with MemAck delayed 3 cycles -> MemReq and the address/byte enables are stable for 4 cycles, Busy high throughout, a single Done pulse, ReadData equals MemRData.
- lw, Addr=0x0000_1002 -> no MemReq, Done with MisalignErr=1 and ReadData=0 one cycle after Start. A following aligned access completes with MisalignErr=0.
- Reset low during REQ -> MemReq drops immediately, all outputs 0. An ack arriving after reset release produces no Done.
